// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 256x8 synchronous memory between two
// masters (A = processor, B = loader/DMA/debug). One access per cycle,
// round-robin or fixed priority on ties, bounded locked bursts, and a
// one-cycle read return with a per-port valid strobe.
module mem_arbiter #(
    parameter int unsigned PRIORITY_A = 0,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       reqA,
    input  logic       weA,
    input  logic       lockA,
    input  logic [7:0] addrA,
    input  logic [7:0] wdataA,
    output logic       gntA,
    output logic       rvalidA,
    output logic [7:0] rdataA,
    input  logic       reqB,
    input  logic       weB,
    input  logic       lockB,
    input  logic [7:0] addrB,
    input  logic [7:0] wdataB,
    output logic       gntB,
    output logic       rvalidB,
    output logic [7:0] rdataB,
    output logic [7:0] memAddr,
    output logic       memStrobe,
    output logic       memWe,
    output logic [7:0] memWdata,
    input  logic [7:0] memDataRead,
    output logic       busy
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    // lastOwner encoded as 1 = B, 0 = A
    logic             last_b_q, last_b_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             pend_a_q, pend_b_q;
    logic [7:0]       addr_q;
    logic             gnt_a_c, gnt_b_c;

    // Grant decision: single requester, locked burst retention, then tie-break
    always_comb begin
        gnt_a_c = 1'b0;
        gnt_b_c = 1'b0;
        if (resetN) begin
            if (reqA && !reqB) begin
                gnt_a_c = 1'b1;
            end else if (reqB && !reqA) begin
                gnt_b_c = 1'b1;
            end else if (reqA && reqB) begin
                if (last_b_q && lockB && (burst_q < BURST_LIMIT)) begin
                    gnt_b_c = 1'b1;
                end else if (!last_b_q && lockA && (burst_q < BURST_LIMIT)) begin
                    gnt_a_c = 1'b1;
                end else if (PRIORITY_A != 0) begin
                    gnt_a_c = 1'b1;
                end else if (last_b_q) begin
                    gnt_a_c = 1'b1;
                end else begin
                    gnt_b_c = 1'b1;
                end
            end
        end
    end

    // Memory-side mux of the granted port; address holds when idle
    always_comb begin
        memAddr   = addr_q;
        memWdata  = {DATA_W{1'b0}};
        memWe     = 1'b0;
        memStrobe = 1'b0;
        if (gnt_a_c) begin
            memAddr   = addrA;
            memWdata  = wdataA;
            memWe     = weA;
            memStrobe = ~weA;
        end else if (gnt_b_c) begin
            memAddr   = addrB;
            memWdata  = wdataB;
            memWe     = weB;
            memStrobe = ~weB;
        end
    end

    // Next owner and saturating burst count
    always_comb begin
        last_b_d = last_b_q;
        burst_d  = {CNT_W{1'b0}};
        if (gnt_a_c || gnt_b_c) begin
            if (gnt_b_c == last_b_q) begin
                burst_d = (burst_q == CNT_MAX) ? CNT_MAX : burst_q + CNT_W'(1);
            end else begin
                burst_d  = CNT_W'(1);
                last_b_d = gnt_b_c;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            last_b_q <= 1'b1;
            burst_q  <= {CNT_W{1'b0}};
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            addr_q   <= 8'h00;
        end else begin
            last_b_q <= last_b_d;
            burst_q  <= burst_d;
            pend_a_q <= gnt_a_c & ~weA;
            pend_b_q <= gnt_b_c & ~weB;
            addr_q   <= memAddr;
        end
    end

    // Read return; an asserted reset drops any outstanding valid immediately
    always_comb begin
        gntA    = gnt_a_c;
        gntB    = gnt_b_c;
        rvalidA = pend_a_q & resetN;
        rvalidB = pend_b_q & resetN;
        rdataA  = rvalidA ? memDataRead : {DATA_W{1'b0}};
        rdataB  = rvalidB ? memDataRead : {DATA_W{1'b0}};
        busy    = gnt_a_c | gnt_b_c | rvalidA | rvalidB;
    end

endmodule
